// File: rtl/io_char_out_pkg.sv
// io_char_out_pkg: register map offsets, STATUS bit layout and helpers
// shared by the character-output block and its channel FIFOs.
package io_char_out_pkg;

    // Register offsets within one channel's address pair
    localparam int unsigned OFF_DATA  = 0;
    localparam int unsigned OFF_CTRL  = 1;
    localparam int unsigned CH_STRIDE = 2;

    // STATUS register bit positions
    localparam int unsigned ST_OVF    = 7;
    localparam int unsigned ST_IE     = 6;
    localparam int unsigned ST_CNT_HI = 5;
    localparam int unsigned ST_CNT_LO = 2;
    localparam int unsigned ST_EMPTY  = 1;
    localparam int unsigned ST_FULL   = 0;

    // Widest FIFO count (DEPTH = 256 -> 9 bits)
    localparam int unsigned CNT_MAX_W = 9;

    typedef struct packed {
        logic                 ovf;
        logic                 ie;
        logic [CNT_MAX_W-1:0] count;
        logic                 empty;
        logic                 full;
    } chan_status_t;

    // Occupancy as shown in STATUS: saturates at 15
    function automatic logic [3:0] sat_count(input logic [CNT_MAX_W-1:0] count);
        if (count > CNT_MAX_W'(15))
            return 4'hF;
        else
            return count[3:0];
    endfunction

    // Pack a channel's state into the STATUS byte
    function automatic logic [7:0] status_byte(input chan_status_t s);
        logic [7:0] b;
        b                      = '0;
        b[ST_OVF]              = s.ovf;
        b[ST_IE]               = s.ie;
        b[ST_CNT_HI:ST_CNT_LO] = sat_count(s.count);
        b[ST_EMPTY]            = s.empty;
        b[ST_FULL]             = s.full;
        return b;
    endfunction

endpackage

// File: rtl/io_char_out_char_fifo.sv
// char_fifo: single-clock circular buffer for one output channel.
// A push to a full buffer is accepted only when a pop happens in the same
// cycle; otherwise it is dropped and the caller flags the overflow.
module char_fifo
    import io_char_out_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Storage write; when full with a simultaneous pop, the slot being
    // vacated is exactly the one written
    always_ff @(posedge clock) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    // Pointer and occupancy update; pointers wrap naturally (DEPTH is 2^AW)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_char_out.sv
// io_char_out: I/O-mapped character output block with NCH buffered
// channels. Each channel has a DATA/STATUS register and a CTRL register.
// Optional simulation echo of popped characters: IO_CHAR_OUT_DISPLAY_EN.
module io_char_out
    import io_char_out_pkg::*;
#(
    parameter int unsigned NCH       = 2,
    parameter int unsigned DEPTH     = 8,
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ior_,
    input  logic               iow_,
    input  logic [15:0]        a15_a0,
    input  logic [7:0]         d7_d0_in,
    output logic [7:0]         d7_d0_out,
    output logic               d7_d0_oe,
    output logic [NCH-1:0]     tx_valid,
    output logic [8*NCH-1:0]   tx_data,
    input  logic [NCH-1:0]     tx_ready,
    output logic               irq
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic           iow_q;
    logic           ior_q;
    logic           wr_arm;
    logic           wr_start;
    logic           rd_end;

    logic [NCH-1:0] sel_data;
    logic [NCH-1:0] sel_ctrl;
    logic [NCH-1:0] push;
    logic [NCH-1:0] pop;
    logic [NCH-1:0] full;
    logic [NCH-1:0] empty;
    logic [NCH-1:0] ovf;
    logic [NCH-1:0] ie;
    logic [7:0]     status_b [NCH];
    logic [7:0]     rd_data;
    logic           rd_hit;

    // Strobe samples; wr_arm records that iow_ has been seen high since
    // reset, so a write strobe already low at reset release never pushes
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            iow_q  <= 1'b1;
            ior_q  <= 1'b1;
            wr_arm <= 1'b0;
        end else begin
            iow_q  <= iow_;
            ior_q  <= ior_;
            wr_arm <= wr_arm | iow_;
        end
    end

    // Strobe edges; both strobes low at once are ignored
    assign wr_start = wr_arm & iow_q & ~iow_ & ior_;
    assign rd_end   = ~ior_q & ior_ & iow_q;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        localparam logic [15:0] DATA_ADDR = 16'(BASE_ADDR + CH_STRIDE * c + OFF_DATA);
        localparam logic [15:0] CTRL_ADDR = 16'(BASE_ADDR + CH_STRIDE * c + OFF_CTRL);

        logic          ovf_r;
        logic          ie_r;
        logic [CW-1:0] count;
        chan_status_t  st;

        assign sel_data[c] = (a15_a0 == DATA_ADDR);
        assign sel_ctrl[c] = (a15_a0 == CTRL_ADDR);
        assign push[c]     = wr_start & sel_data[c];
        assign pop[c]      = tx_valid[c] & tx_ready[c];
        assign tx_valid[c] = ~empty[c];
        assign ovf[c]      = ovf_r;
        assign ie[c]       = ie_r;

        char_fifo #(
            .DEPTH (DEPTH),
            .WIDTH (8)
        ) u_fifo (
            .clock     (clock),
            .reset     (reset),
            .push      (push[c]),
            .push_data (d7_d0_in),
            .pop       (pop[c]),
            .head      (tx_data[8*c +: 8]),
            .full      (full[c]),
            .empty     (empty[c]),
            .count     (count)
        );

        // Sticky overflow (set on a dropped push, cleared when a STATUS
        // read ends) and interrupt enable (set from a CTRL write)
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                ovf_r <= 1'b0;
                ie_r  <= 1'b0;
            end else begin
                if (push[c] & full[c] & ~pop[c])
                    ovf_r <= 1'b1;
                else if (rd_end & sel_data[c])
                    ovf_r <= 1'b0;
                if (wr_start & sel_ctrl[c])
                    ie_r <= d7_d0_in[0];
            end
        end

        // STATUS byte for this channel
        always_comb begin
            st.ovf      = ovf_r;
            st.ie       = ie_r;
            st.count    = CNT_MAX_W'(count);
            st.empty    = empty[c];
            st.full     = full[c];
            status_b[c] = status_byte(st);
        end
    end

    // Read-data mux across all channel registers
    always_comb begin
        rd_data = '0;
        rd_hit  = 1'b0;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (sel_data[c]) begin
                rd_data = status_b[c];
                rd_hit  = 1'b1;
            end
            if (sel_ctrl[c]) begin
                rd_data = {7'b0, ie[c]};
                rd_hit  = 1'b1;
            end
        end
    end

    assign d7_d0_out = rd_data;
    assign d7_d0_oe  = rd_hit & ~ior_ & ~reset;

    // Registered interrupt: enabled-and-empty or overflowed on any channel
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            irq <= 1'b0;
        else
            irq <= |((ie & empty) | ovf);
    end

`ifdef IO_CHAR_OUT_DISPLAY_EN
    // Echo each popped character, lowest channel first
    always_ff @(posedge clock) begin
        for (int unsigned c = 0; c < NCH; c++) begin
            if (!reset && pop[c])
                $write("%c", tx_data[8*c +: 8]);
        end
    end
`endif

endmodule

// File: tb/tb_io_char_out.sv
// tb_io_char_out: directed self-checking bench for io_char_out
// (NCH=2, DEPTH=8, BASE_ADDR=16'h0040).
module tb_io_char_out;

    localparam logic [15:0] DATA0 = 16'h0040;
    localparam logic [15:0] CTRL0 = 16'h0041;
    localparam logic [15:0] DATA1 = 16'h0042;
    localparam logic [15:0] CTRL1 = 16'h0043;

    logic        clock = 1'b0;
    logic        reset;
    logic        ior_;
    logic        iow_;
    logic [15:0] a;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        oe;
    logic [1:0]  tx_valid;
    logic [15:0] tx_data;
    logic [1:0]  tx_ready;
    logic        irq;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  cap0 [$];

    io_char_out #(
        .NCH       (2),
        .DEPTH     (8),
        .BASE_ADDR (16'h0040)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .ior_      (ior_),
        .iow_      (iow_),
        .a15_a0    (a),
        .d7_d0_in  (din),
        .d7_d0_out (dout),
        .d7_d0_oe  (oe),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .irq       (irq)
    );

    always #5 clock = ~clock;

    // Record every character channel 0 hands to its sink
    always @(posedge clock) begin
        if (!reset && tx_valid[0] && tx_ready[0])
            cap0.push_back(tx_data[7:0]);
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] addr, input logic [7:0] data);
        @(negedge clock);
        a    = addr;
        din  = data;
        iow_ = 1'b0;
        @(negedge clock);
        iow_ = 1'b1;
        @(negedge clock);
    endtask

    task automatic rd(input logic [15:0] addr, output logic [7:0] data, output logic oe_s);
        @(negedge clock);
        a    = addr;
        ior_ = 1'b0;
        #1;
        data = dout;
        oe_s = oe;
        @(negedge clock);
        ior_ = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        logic [7:0] v;
        logic       o;

        reset    = 1'b1;
        ior_     = 1'b1;
        iow_     = 1'b1;
        a        = '0;
        din      = '0;
        tx_ready = '0;

        // Reset state, including a read attempted while in reset
        repeat (2) @(negedge clock);
        a    = DATA0;
        ior_ = 1'b0;
        #1;
        check("rst_oe", {15'd0, oe}, 16'd0);
        check("rst_tx_valid", {14'd0, tx_valid}, 16'd0);
        check("rst_irq", {15'd0, irq}, 16'd0);
        ior_ = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        rd(DATA0, v, o);
        check("status0_after_rst", {8'd0, v}, 16'h0002);
        check("status0_oe", {15'd0, o}, 16'd1);
        rd(CTRL0, v, o);
        check("ctrl0_after_rst", {8'd0, v}, 16'h0000);
        rd(16'h0044, v, o);
        check("unsel_hi_data", {8'd0, v}, 16'h0000);
        check("unsel_hi_oe", {15'd0, o}, 16'd0);
        rd(16'h003F, v, o);
        check("unsel_lo_oe", {15'd0, o}, 16'd0);

        // Three characters streamed straight through channel 0
        tx_ready = 2'b01;
        wr(DATA0, 8'h41);
        wr(DATA0, 8'h42);
        wr(DATA0, 8'h43);
        repeat (3) @(negedge clock);
        check("abc_count", 16'(cap0.size()), 16'd3);
        if (cap0.size() == 3) begin
            check("abc_0", {8'd0, cap0[0]}, 16'h0041);
            check("abc_1", {8'd0, cap0[1]}, 16'h0042);
            check("abc_2", {8'd0, cap0[2]}, 16'h0043);
        end
        check("abc_valid_drop", {14'd0, tx_valid}, 16'd0);
        tx_ready = 2'b00;
        cap0.delete();

        // Overflow: nine writes into an eight-deep FIFO
        for (int i = 0; i < 9; i++)
            wr(DATA0, 8'(8'h30 + i));
        check("ovf_irq", {15'd0, irq}, 16'd1);
        check("ovf_head_stable", {8'd0, tx_data[7:0]}, 16'h0030);
        rd(DATA0, v, o);
        check("ovf_status_1st", {8'd0, v}, 16'h00A1);
        rd(DATA0, v, o);
        check("ovf_status_2nd", {8'd0, v}, 16'h0021);
        check("ovf_irq_cleared", {15'd0, irq}, 16'd0);

        // Full FIFO: push and pop in the same cycle
        @(negedge clock);
        a        = DATA0;
        din      = 8'h77;
        iow_     = 1'b0;
        tx_ready = 2'b01;
        @(negedge clock);
        tx_ready = 2'b00;
        iow_     = 1'b1;
        @(negedge clock);
        rd(DATA0, v, o);
        check("pushpop_status", {8'd0, v}, 16'h0021);
        check("pushpop_head", {8'd0, tx_data[7:0]}, 16'h0031);
        check("pushpop_irq", {15'd0, irq}, 16'd0);
        tx_ready = 2'b01;
        repeat (12) @(negedge clock);
        tx_ready = 2'b00;
        check("drain_count", 16'(cap0.size()), 16'd9);
        if (cap0.size() == 9) begin
            check("drain_first", {8'd0, cap0[0]}, 16'h0030);
            check("drain_second", {8'd0, cap0[1]}, 16'h0031);
            check("drain_last", {8'd0, cap0[8]}, 16'h0077);
        end
        rd(DATA0, v, o);
        check("drain_status", {8'd0, v}, 16'h0002);

        // Long write strobe on channel 1
        @(negedge clock);
        a    = DATA1;
        din  = 8'h5A;
        iow_ = 1'b0;
        repeat (10) @(negedge clock);
        iow_ = 1'b1;
        @(negedge clock);
        rd(DATA1, v, o);
        check("long_status1", {8'd0, v}, 16'h0004);
        rd(DATA0, v, o);
        check("long_status0", {8'd0, v}, 16'h0002);
        check("long_valid", {14'd0, tx_valid}, 16'h0002);
        check("long_data1", {8'd0, tx_data[15:8]}, 16'h005A);

        // Interrupt on enabled-and-empty channel 1
        tx_ready = 2'b10;
        repeat (2) @(negedge clock);
        tx_ready = 2'b00;
        check("irq_before_ie", {15'd0, irq}, 16'd0);
        a    = CTRL1;
        din  = 8'h01;
        iow_ = 1'b0;
        @(posedge clock);
        #1;
        check("irq_ie_edge", {15'd0, irq}, 16'd0);
        @(posedge clock);
        #1;
        check("irq_ie_set", {15'd0, irq}, 16'd1);
        @(negedge clock);
        iow_ = 1'b1;
        @(negedge clock);
        rd(CTRL1, v, o);
        check("ctrl1_read", {8'd0, v}, 16'h0001);
        a    = DATA1;
        din  = 8'h61;
        iow_ = 1'b0;
        @(posedge clock);
        #1;
        check("irq_push_edge", {15'd0, irq}, 16'd1);
        @(posedge clock);
        #1;
        check("irq_after_push", {15'd0, irq}, 16'd0);
        @(negedge clock);
        iow_ = 1'b1;
        @(negedge clock);

        // Reset in the middle of a write strobe with three entries queued
        wr(DATA0, 8'h10);
        wr(DATA0, 8'h11);
        wr(DATA0, 8'h12);
        rd(DATA0, v, o);
        check("pre_rst_status0", {8'd0, v}, 16'h000C);
        @(negedge clock);
        a    = DATA0;
        din  = 8'h99;
        iow_ = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("midrst_valid", {14'd0, tx_valid}, 16'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        iow_ = 1'b1;
        repeat (2) @(negedge clock);
        check("postrst_valid", {14'd0, tx_valid}, 16'd0);
        check("postrst_irq", {15'd0, irq}, 16'd0);
        rd(DATA0, v, o);
        check("postrst_status0", {8'd0, v}, 16'h0002);
        rd(DATA1, v, o);
        check("postrst_status1", {8'd0, v}, 16'h0002);
        rd(CTRL1, v, o);
        check("postrst_ctrl1", {8'd0, v}, 16'h0000);

        // Ordinary write still works after reset
        wr(DATA0, 8'h42);
        check("postrst_wr_valid", {14'd0, tx_valid}, 16'h0001);
        check("postrst_wr_data", {8'd0, tx_data[7:0]}, 16'h0042);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/io_char_out.md
IO_CHAR_OUT -- requirements
Module: io_char_out

Interface
REQ-001 SHALL have parameter NCH, default 2, number of character output channels (1..8).
REQ-002 SHALL have parameter DEPTH, default 8, FIFO depth per channel (power of two, 2..256).
REQ-003 SHALL have parameter BASE_ADDR, default 16'h0000, first I/O address of the block.
REQ-004 SHALL have port clock  in  1  single clock; all state on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port ior_  in  1  I/O read strobe, active low.
REQ-007 SHALL have port iow_  in  1  I/O write strobe, active low.
REQ-008 SHALL have port a15_a0  in  16  I/O address.
REQ-009 SHALL have port d7_d0_in  in  8  write data.
REQ-010 SHALL have port d7_d0_out  out  8  read data.
REQ-011 SHALL have port d7_d0_oe  out  1  read data valid; high while ior_=0 and the address selects a register.
REQ-012 SHALL have port tx_valid  out  NCH  per-channel character available.
REQ-013 SHALL have port tx_data  out  8*NCH  per-channel character; channel c in bits [8c+7:8c].
REQ-014 SHALL have port tx_ready  in  NCH  per-channel sink accepts the character.
REQ-015 SHALL have port irq  out  1  interrupt request, active high.

Function
REQ-016 SHALL map channel c to DATA/STATUS at BASE_ADDR+2c and CTRL at BASE_ADDR+2c+1; other addresses are unselected.
REQ-017 SHALL register iow_ and ior_ each cycle and detect a strobe start as a 1->0 transition (previous sample 1, current 0).
REQ-018 SHALL push d7_d0_in into channel c FIFO on a write strobe start at DATA(c): exactly one push per strobe, however long it lasts.
REQ-019 SHALL drop a push to a full FIFO and set sticky OVF(c), except when the same cycle pops; then the push is accepted and the count is unchanged.
REQ-020 SHALL drive d7_d0_out combinationally: STATUS = {OVF, IE, count[3:0] saturated at 15, EMPTY, FULL} in bits 7,6,5:2,1,0; CTRL read = {7'b0, IE}; unselected = 8'h00.
REQ-021 SHALL clear OVF(c) on the 0->1 transition of ior_ ending a read of STATUS(c), so the read returns the pre-clear value.
REQ-022 SHALL set IE(c) = d7_d0_in[0] on a write strobe start at CTRL(c).
REQ-023 SHALL assert tx_valid(c) whenever FIFO c is non-empty, tx_data(c) = head entry; pop when tx_valid & tx_ready in the same cycle.
REQ-024 SHALL keep tx_data stable while tx_valid=1 and tx_ready=0.
REQ-025 SHALL assert irq = OR over c of (IE(c) & EMPTY(c)) | OVF(c), registered (one-cycle latency).
REQ-026 SHALL wrap FIFO read/write pointers modulo DEPTH; count is log2(DEPTH)+1 bits.
REQ-027 SHALL ignore strobes with both ior_ and iow_ low.

Reset
REQ-028 SHALL on reset empty all FIFOs, clear OVF and IE, set registered strobe samples to 1, and drive tx_valid=0, irq=0, d7_d0_oe=0.
REQ-029 SHALL abort any strobe in progress at reset; a strobe still low when reset releases SHALL NOT push.

Configuration
REQ-030 SHALL, with IO_CHAR_OUT_DISPLAY_EN defined, print each popped character in simulation with $write("%c") prefixed by nothing, channel order ascending within a cycle.
REQ-031 SHALL, without IO_CHAR_OUT_DISPLAY_EN, contain no simulation print statements; behaviour otherwise identical.

Structure
REQ-032 SHALL place register offsets (DATA=0, CTRL=1), STATUS bit positions and the channel stride (2) in package io_char_out_pkg.
REQ-033 SHALL implement each channel buffer as one instance of sub-module char_fifo (parameter DEPTH, width 8, push/pop/full/empty/count).

Verification
REQ-034 SHALL test: write 'A','B','C' to DATA(0) with tx_ready(0)=1 -> tx_data(0) shows 8'h41, 8'h42, 8'h43 in order, tx_valid(0) then drops.
REQ-035 SHALL test: DEPTH=8, tx_ready(0)=0, 9 writes -> STATUS(0) reads 8'b1_0_1000_0_1 (OVF, count 8, FULL); a second read returns OVF=0.
REQ-036 SHALL test: iow_ held low 10 cycles at DATA(1) with 8'h5A -> exactly one push, count(1)=1, channel 0 unaffected.
REQ-037 SHALL test: FIFO full, push and pop in same cycle -> push accepted, count stays 8, no OVF.
REQ-038 SHALL test: write 8'h01 to CTRL(1) with FIFO 1 empty -> irq=1 one cycle later; write a char -> irq=0 once the write is registered.
REQ-039 SHALL test: reset asserted mid-strobe with 3 entries queued -> tx_valid=0, STATUS reads 8'h02, no push after release.
